// File: rtl/raw_pattern_pkg.sv
// ---------------------------------------------------------------------------
// raw_pattern_pkg
// Shared types and constants for the RAW Bayer test-pattern transmitter:
// FSM state encoding, pattern_sel encodings, GRBG Bayer phase constants,
// the colour-bar RGB table and the box / checkerboard geometry.
// ---------------------------------------------------------------------------
package raw_pattern_pkg;

  localparam int CNT_W       = 16;  // width of the x/y/cycle counters
  localparam int PIX_W       = 10;  // RAW pixel width
  localparam int BOX_SIZE    = 64;  // green box edge length in pixels
  localparam int CHECK_SHIFT = 5;   // checkerboard cell = 2**CHECK_SHIFT pixels

  typedef enum logic [2:0] {
    IDLE,
    FV_LEAD,
    LINE,
    HBLANK,
    FV_TRAIL,
    VBLANK
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_BOX     = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  // Bayer phase is {y[0], x[0]}; GRBG mosaic.
  localparam logic [1:0] PH_GR = 2'b00;  // green on a red row
  localparam logic [1:0] PH_R  = 2'b01;
  localparam logic [1:0] PH_B  = 2'b10;
  localparam logic [1:0] PH_GB = 2'b11;  // green on a blue row

  // One bit per component: 1 means full scale (0x3FF), 0 means zero.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  // Colour bars, left to right, encoded {r, g, b}.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111,  // white
    3'b110,  // yellow
    3'b011,  // cyan
    3'b010,  // green
    3'b101,  // magenta
    3'b100,  // red
    3'b001,  // blue
    3'b000   // black
  };

  // Configuration captured at the start of every frame.
  typedef struct packed {
    pattern_e   sel;
    logic [9:0] box_x;
    logic [8:0] box_y;
  } cfg_t;

  function automatic logic [1:0] bayer_phase(input logic x0, input logic y0);
    return {y0, x0};
  endfunction

endpackage

// File: rtl/raw_pattern_tx_if.sv
// ---------------------------------------------------------------------------
// raw_pattern_tx_if
// Control inputs and pixel outputs of raw_pattern_tx.
//   enable       : high starts frames and keeps them running
//   pattern_sel  : 0 bars, 1 ramp, 2 green box, 3 checkerboard
//   box_x/box_y  : top-left corner of the green box
//   pix_d        : RAW Bayer pixel, valid while pix_hs=1
//   pix_hs/pix_vs: line valid / frame valid
//   frame_done   : one-cycle pulse as pix_vs falls
//   busy         : FSM not idle
//   frame_cnt    : completed frames, wrapping
// master drives the controls (the source user), slave is the generator.
// ---------------------------------------------------------------------------
interface raw_pattern_tx_if;
  import raw_pattern_pkg::*;

  logic             enable;
  logic [1:0]       pattern_sel;
  logic [9:0]       box_x;
  logic [8:0]       box_y;
  logic [PIX_W-1:0] pix_d;
  logic             pix_hs;
  logic             pix_vs;
  logic             frame_done;
  logic             busy;
  logic [15:0]      frame_cnt;

  modport master (
    output enable, pattern_sel, box_x, box_y,
    input  pix_d, pix_hs, pix_vs, frame_done, busy, frame_cnt
  );

  modport slave (
    input  enable, pattern_sel, box_x, box_y,
    output pix_d, pix_hs, pix_vs, frame_done, busy, frame_cnt
  );

endinterface

// File: rtl/raw_pattern_pixel.sv
// ---------------------------------------------------------------------------
// raw_pattern_pixel
// Purely combinational map from (x, y, latched config) to a GRBG Bayer sample.
//   x, y : pixel coordinates inside the active area
//   cfg  : pattern and box position latched at frame start
//   pix  : 10-bit RAW value for that position
// ---------------------------------------------------------------------------
module raw_pattern_pixel
  import raw_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  cfg_t             cfg,
  output logic [PIX_W-1:0] pix
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]   bar_idx;
  logic [CNT_W:0] x_ext, y_ext;
  logic [CNT_W:0] box_x_lo, box_x_hi, box_y_lo, box_y_hi;
  logic         in_box;
  logic         chk_black;
  rgb_t         rgb;
  logic         comp;

  // Bar index by threshold compare, avoiding a divider for non-power-of-two
  // bar widths.
  // NOTE: every variable written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (x >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  // One extra bit so box_x+63 / box_y+63 can never wrap below the origin.
  assign x_ext    = {1'b0, x};
  assign y_ext    = {1'b0, y};
  assign box_x_lo = (CNT_W + 1)'(cfg.box_x);
  assign box_y_lo = (CNT_W + 1)'(cfg.box_y);
  assign box_x_hi = box_x_lo + (CNT_W + 1)'(BOX_SIZE - 1);
  assign box_y_hi = box_y_lo + (CNT_W + 1)'(BOX_SIZE - 1);
  assign in_box   = (x_ext >= box_x_lo) && (x_ext <= box_x_hi) &&
                    (y_ext >= box_y_lo) && (y_ext <= box_y_hi);

  assign chk_black = x[CHECK_SHIFT] ^ y[CHECK_SHIFT];

  always_comb begin
    rgb = '0;
    case (cfg.sel)
      PAT_BARS:    rgb = rgb_t'(BAR_RGB[bar_idx]);
      PAT_BOX:     rgb.g = in_box;
      PAT_CHECKER: rgb = chk_black ? rgb_t'(3'b000) : rgb_t'(3'b111);
      default:     rgb = '0;
    endcase
  end

  always_comb begin
    comp = 1'b0;
    case (bayer_phase(x[0], y[0]))
      PH_R:    comp = rgb.r;
      PH_B:    comp = rgb.b;
      default: comp = rgb.g;  // PH_GR and PH_GB
    endcase
    pix = (cfg.sel == PAT_RAMP) ? x[PIX_W-1:0] : {PIX_W{comp}};
  end

endmodule

// File: rtl/raw_pattern_tx.sv
// ---------------------------------------------------------------------------
// raw_pattern_tx
// RAW Bayer test-pattern source with parallel-sensor style framing.
//   clk : pixel clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : raw_pattern_tx_if.slave (controls in, pixel stream and status out)
// Frame: FV_LEAD -> V_ACTIVE x (LINE, HBLANK) with the last HBLANK replaced
// by FV_TRAIL -> VBLANK. Every output is registered from the current state,
// so all outputs lag the state register by the same single cycle and keep
// their mutual alignment.
// ---------------------------------------------------------------------------
module raw_pattern_tx
  import raw_pattern_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 160,
  parameter int FV_LV       = 16,
  parameter int V_BLANK_CYC = 8000
) (
  input  logic              clk,
  input  logic              rst,
  raw_pattern_tx_if.slave   bus
);

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;   // cycles spent in a non-LINE state
  logic [CNT_W-1:0]  x, x_n;
  logic [CNT_W-1:0]  y, y_n;
  cfg_t              cfg;
  logic              load_cfg;

  logic [PIX_W-1:0]  pix_val;
  logic              vs_now;
  logic              frame_end;

  logic [PIX_W-1:0]  pix_d_q;
  logic              pix_hs_q, pix_vs_q, frame_done_q, busy_q;
  logic [15:0]       frame_cnt_q;

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    x_n      = x;
    y_n      = y;
    load_cfg = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        x_n   = '0;
        y_n   = '0;
        if (bus.enable) begin
          state_n  = FV_LEAD;
          load_cfg = 1'b1;
        end
      end

      FV_LEAD: begin
        if (cnt == CNT_W'(FV_LV - 1)) begin
          state_n = LINE;
          cnt_n   = '0;
          x_n     = '0;
          y_n     = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      LINE: begin
        if (x == CNT_W'(H_ACTIVE - 1)) begin
          x_n     = '0;
          cnt_n   = '0;
          state_n = (y == CNT_W'(V_ACTIVE - 1)) ? FV_TRAIL : HBLANK;
        end else begin
          x_n = x + CNT_W'(1);
        end
      end

      HBLANK: begin
        if (cnt == CNT_W'(H_BLANK - 1)) begin
          state_n = LINE;
          cnt_n   = '0;
          y_n     = y + CNT_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      FV_TRAIL: begin
        if (cnt == CNT_W'(FV_LV - 1)) begin
          state_n = VBLANK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      VBLANK: begin
        if (cnt == CNT_W'(V_BLANK_CYC - 1)) begin
          cnt_n = '0;
          // A frame in flight always completes; enable only gates the next one.
          if (bus.enable) begin
            state_n  = FV_LEAD;
            load_cfg = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      cfg   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      x     <= x_n;
      y     <= y_n;
      // Controls are sampled only on frame entry so mid-frame changes cannot
      // tear the image.
      if (load_cfg) begin
        cfg <= '{sel:   pattern_e'(bus.pattern_sel),
                 box_x: bus.box_x,
                 box_y: bus.box_y};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pixel generator
  // -------------------------------------------------------------------------
  raw_pattern_pixel #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pixel (
    .x   (x),
    .y   (y),
    .cfg (cfg),
    .pix (pix_val)
  );

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  assign vs_now    = state inside {FV_LEAD, LINE, HBLANK, FV_TRAIL};
  // pix_vs is about to drop: the trail has just finished.
  assign frame_end = pix_vs_q & ~vs_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_d_q      <= '0;
      pix_hs_q     <= 1'b0;
      pix_vs_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      pix_hs_q     <= (state == LINE);
      pix_d_q      <= (state == LINE) ? pix_val : '0;
      pix_vs_q     <= vs_now;
      frame_done_q <= frame_end;
      busy_q       <= (state != IDLE);
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.pix_d      = pix_d_q;
  assign bus.pix_hs     = pix_hs_q;
  assign bus.pix_vs     = pix_vs_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_raw_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_raw_pattern_tx
// Scoreboard bench for raw_pattern_tx. A short frame (4 lines, short blanking)
// keeps run time low while keeping the 640-pixel line so bar and box
// positions are the real ones. Stimulus pushes expected pixels into a queue;
// the monitor tracks (frame, x, y) from pix_vs/pix_hs and checks framing.
// ---------------------------------------------------------------------------
module tb_raw_pattern_tx;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 4;
  localparam int H_BLANK     = 16;
  localparam int FV_LV       = 16;
  localparam int V_BLANK_CYC = 100;
  localparam int WAIT_BUDGET = 20000;

  logic clk;
  logic rst;

  raw_pattern_tx_if bus ();

  raw_pattern_tx #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .FV_LV       (FV_LV),
    .V_BLANK_CYC (V_BLANK_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int         frame;
    int         x;
    int         y;
    logic [9:0] val;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input int f, input int x, input int y, input logic [9:0] v);
    exp_t e;
    e.frame = f;
    e.x     = x;
    e.y     = y;
    e.val   = v;
    sb_q.push_back(e);
  endtask

  function automatic int key_of(input int f, input int y, input int x);
    return f * (1 << 21) + y * (1 << 11) + x;
  endfunction

  // -------------------------------------------------------------------------
  // Monitor: framing checks and scoreboard pops, sampled on the falling edge
  // -------------------------------------------------------------------------
  int          mon_frame  = 0;
  int          mon_done   = 0;
  int          mon_x      = 0;
  int          mon_y      = -1;
  int          lines      = 0;
  int          hs_run     = 0;
  int          hs_low_run = 0;
  int          vs_low_run = 0;
  int          dirty      = 0;
  logic        prev_hs    = 1'b0;
  logic        prev_vs    = 1'b0;
  logic        gap_valid  = 1'b0;
  logic [15:0] model_cnt  = '0;

  always @(negedge clk) begin
    logic vs, hs, vs_fall;
    int   cur;
    if (rst) begin
      prev_hs    = 1'b0;
      prev_vs    = 1'b0;
      gap_valid  = 1'b0;
      model_cnt  = '0;
      lines      = 0;
      hs_run     = 0;
      hs_low_run = 0;
      vs_low_run = 0;
      dirty      = 0;
    end else begin
      vs      = bus.pix_vs;
      hs      = bus.pix_hs;
      vs_fall = prev_vs && !vs;

      if (vs && !prev_vs) begin
        if (gap_valid) check("vblank_len", vs_low_run, V_BLANK_CYC);
        mon_frame++;
        mon_y      = -1;
        lines      = 0;
        hs_low_run = 0;
      end

      if (vs_fall) begin
        check("lines_per_frame", lines, V_ACTIVE);
        check("fv_trail_len", hs_low_run, FV_LV);
        check("pix_d_zero_when_hs_low", dirty, 0);
        dirty      = 0;
        mon_done++;
        vs_low_run = 0;
        gap_valid  = 1'b1;
      end

      if (hs && !prev_hs) begin
        if (lines == 0) check("fv_lead_len", hs_low_run, FV_LV);
        else            check("hblank_len", hs_low_run, H_BLANK);
        lines++;
        mon_y++;
        mon_x  = 0;
        hs_run = 0;
      end

      if (!hs && prev_hs) begin
        check("line_len", hs_run, H_ACTIVE);
        hs_low_run = 0;
      end

      if (hs) begin
        hs_run++;
        cur = key_of(mon_frame, mon_y, mon_x);
        while (sb_q.size() > 0 && key_of(sb_q[0].frame, sb_q[0].y, sb_q[0].x) < cur) begin
          check($sformatf("pixel_order f%0d(%0d,%0d)", sb_q[0].frame, sb_q[0].x, sb_q[0].y),
                cur, key_of(sb_q[0].frame, sb_q[0].y, sb_q[0].x));
          void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && key_of(sb_q[0].frame, sb_q[0].y, sb_q[0].x) == cur) begin
          check($sformatf("pixel f%0d(%0d,%0d)", mon_frame, mon_x, mon_y),
                int'(bus.pix_d), int'(sb_q[0].val));
          void'(sb_q.pop_front());
        end
        mon_x++;
      end else begin
        if (vs) hs_low_run++;
        if (bus.pix_d != '0) dirty++;
      end

      if (!vs) begin
        vs_low_run++;
        if (!bus.enable) gap_valid = 1'b0;
      end

      if (bus.frame_done || vs_fall) check("frame_done_at_vs_fall", int'(bus.frame_done), int'(vs_fall));
      if (bus.frame_done) begin
        model_cnt = model_cnt + 16'd1;
        check("frame_cnt", int'(bus.frame_cnt), int'(model_cnt));
      end

      prev_hs = hs;
      prev_vs = vs;
    end
  end

  // -------------------------------------------------------------------------
  // Bounded waits
  // -------------------------------------------------------------------------
  task automatic wait_frame_start(input int n);
    int budget = WAIT_BUDGET;
    while (mon_frame < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check($sformatf("reach_frame_%0d", n), int'(mon_frame >= n), 1);
  endtask

  task automatic wait_frames_done(input int n);
    int budget = WAIT_BUDGET;
    while (mon_done < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check($sformatf("frames_done_%0d", n), int'(mon_done >= n), 1);
  endtask

  task automatic wait_line(input int f, input int l);
    int budget = WAIT_BUDGET;
    while (!(mon_frame == f && mon_y >= l) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check($sformatf("reach_f%0d_line_%0d", f, l), int'(mon_frame == f && mon_y >= l), 1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.pattern_sel = 2'd1;
    bus.box_x       = 10'd100;
    bus.box_y       = 9'd2;

    repeat (3) @(posedge clk);
    #1;
    check("reset_pix_vs", int'(bus.pix_vs), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_frame_cnt", int'(bus.frame_cnt), 0);

    // Frame 1: ramp, first and last line in full.
    for (int xi = 0; xi < H_ACTIVE; xi++) push(1, xi, 0, 10'(xi));
    for (int xi = 0; xi < H_ACTIVE; xi++) push(1, xi, V_ACTIVE - 1, 10'(xi));

    bus.enable = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1 check("vs_after_edge1", int'(bus.pix_vs), 0);
    @(posedge clk) #1 check("vs_after_edge2", int'(bus.pix_vs), 1);

    // Frame 2: colour bars, selected mid-frame 1.
    wait_frame_start(1);
    bus.pattern_sel = 2'd0;
    push(2, 0,   0, 10'h3FF);  // white G
    push(2, 1,   0, 10'h3FF);  // white R
    push(2, 81,  0, 10'h3FF);  // yellow R
    push(2, 240, 0, 10'h3FF);  // green G
    push(2, 241, 0, 10'h000);  // green R
    push(2, 400, 0, 10'h000);  // red G
    push(2, 401, 0, 10'h3FF);  // red R
    push(2, 160, 1, 10'h3FF);  // cyan B
    push(2, 480, 1, 10'h3FF);  // blue B
    push(2, 481, 1, 10'h000);  // blue G
    push(2, 560, 1, 10'h000);  // black B

    // Frame 3: green box at (100,2).
    wait_frame_start(2);
    bus.pattern_sel = 2'd2;
    push(3, 100, 0, 10'h000);
    push(3, 100, 1, 10'h000);
    push(3, 100, 2, 10'h3FF);
    push(3, 101, 2, 10'h000);
    push(3, 162, 2, 10'h3FF);
    push(3, 164, 2, 10'h000);
    push(3, 101, 3, 10'h3FF);
    push(3, 163, 3, 10'h3FF);
    push(3, 165, 3, 10'h000);

    // Move the box mid-frame 3; only frame 4 follows.
    wait_frame_start(3);
    bus.box_x = 10'd200;
    push(4, 100, 2, 10'h000);
    push(4, 200, 2, 10'h3FF);
    push(4, 201, 2, 10'h000);
    push(4, 201, 3, 10'h3FF);
    push(4, 263, 3, 10'h3FF);
    push(4, 265, 3, 10'h000);

    // Frame 5: checkerboard, enable dropped partway through.
    wait_frame_start(4);
    bus.pattern_sel = 2'd3;
    push(5, 0,  0, 10'h3FF);
    push(5, 32, 0, 10'h000);
    push(5, 64, 0, 10'h3FF);
    push(5, 1,  1, 10'h3FF);
    push(5, 33, 1, 10'h000);
    push(5, 65, 1, 10'h3FF);

    wait_frame_start(5);
    wait_line(5, 2);
    bus.enable = 1'b0;
    wait_frames_done(5);
    repeat (V_BLANK_CYC + 5) @(posedge clk);
    #1;
    check("idle_pix_vs", int'(bus.pix_vs), 0);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_frame_cnt", int'(bus.frame_cnt), 5);
    check("idle_no_new_frame", mon_frame, 5);

    // Frame 6: reset in the middle of a line.
    bus.pattern_sel = 2'd1;
    bus.enable      = 1'b1;
    wait_frame_start(6);
    wait_line(6, 1);
    repeat (10) @(posedge clk);
    #1 check("hs_before_reset", int'(bus.pix_hs), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_pix_d", int'(bus.pix_d), 0);
    check("rst_pix_hs", int'(bus.pix_hs), 0);
    check("rst_pix_vs", int'(bus.pix_vs), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_cnt", int'(bus.frame_cnt), 0);

    // Frame 7: restarts cleanly at (0,0).
    push(7, 0,   0, 10'h000);
    push(7, 1,   0, 10'h001);
    push(7, 639, 0, 10'h27F);
    push(7, 5,   3, 10'h005);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_frame_start(7);
    bus.enable = 1'b0;
    wait_frames_done(6);
    repeat (V_BLANK_CYC + 5) @(posedge clk);
    #1;
    check("final_frame_cnt", int'(bus.frame_cnt), 1);
    check("final_busy", int'(bus.busy), 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/raw_pattern_tx.md
RAW_PATTERN_TX -- requirements
Module: raw_pattern_tx

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter H_BLANK, default 160, cycles with pix_hs low between lines.
REQ-004 Parameter FV_LV, default 16, cycles between pix_vs rise and first pix_hs rise, and between last pix_hs fall and pix_vs fall.
REQ-005 Parameter V_BLANK_CYC, default 8000, cycles with pix_vs low between frames.
REQ-006 One clock; reset is asynchronous and active-high. Ports are named clk and rst.
REQ-007 clk  in  1  pixel clock; all logic on its rising edge.
REQ-008 rst  in  1  asynchronous reset, active-high.
REQ-009 enable  in  1  high starts frames and keeps them running.
REQ-010 pattern_sel  in  2  pattern select: 0 colour bars, 1 ramp, 2 green box, 3 checkerboard.
REQ-011 box_x  in  10  left column of the green box.
REQ-012 box_y  in  9  top row of the green box.
REQ-013 pix_d  out  10  RAW Bayer pixel, valid while pix_hs=1.
REQ-014 pix_hs  out  1  line valid.
REQ-015 pix_vs  out  1  frame valid.
REQ-016 frame_done  out  1  one-cycle pulse when pix_vs falls.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 frame_cnt  out  16  completed frames; wraps from 0xFFFF to 0.

Function
REQ-019 The FSM SHALL have the states IDLE, FV_LEAD, LINE, HBLANK, FV_TRAIL and VBLANK.
- IDLE -> FV_LEAD when enable=1.
- FV_LEAD (FV_LV cycles) -> LINE.
- LINE (H_ACTIVE cycles) -> HBLANK, or -> FV_TRAIL after line V_ACTIVE-1.
- HBLANK (H_BLANK cycles) -> LINE.
- FV_TRAIL (FV_LV cycles) -> VBLANK.
- VBLANK (V_BLANK_CYC cycles) -> FV_LEAD if enable=1, else -> IDLE.
REQ-020 All outputs SHALL be registered.
- pix_vs=1 in FV_LEAD, LINE, HBLANK and FV_TRAIL.
- pix_hs=1 only in LINE.
- pix_d SHALL be 0 whenever pix_hs=0.
REQ-021 The x counter (0..H_ACTIVE-1) and y counter (0..V_ACTIVE-1) SHALL both be 0 on the first pixel of a frame; pix_d for (x,y) SHALL appear in the same cycle as the pix_hs-high cycle for that pixel.
REQ-022 Bayer order SHALL be GRBG: even y gives G at even x and R at odd x; odd y gives B at even x and G at odd x.
REQ-023 pix_d SHALL be the RGB component, each component 0 or 0x3FF, selected by the Bayer position.
REQ-024 Colour bars SHALL be 8 bars of H_ACTIVE/8 columns each, in the order white, yellow, cyan, green, magenta, red, blue, black.
REQ-025 Ramp: pix_d SHALL equal x[9:0] at every Bayer position.
REQ-026 Green box: G=0x3FF and R=B=0 for box_x<=x<=box_x+63 and box_y<=y<=box_y+63; all components 0 elsewhere.
- The box SHALL be clipped at the frame edges.
- Computing box_x+63 and box_y+63 SHALL NOT wrap the compare.
REQ-027 Checkerboard: 32x32 cells; white when x[5]^y[5]=0, black otherwise.
REQ-028 pattern_sel, box_x and box_y SHALL be latched on entry to FV_LEAD; changes mid-frame SHALL take effect only from the next frame.
REQ-029 Deasserting enable mid-frame SHALL NOT truncate the frame: the frame completes, VBLANK runs, then the FSM goes to IDLE.
REQ-030 In the FV_TRAIL->VBLANK transition cycle: frame_done=1 and frame_cnt increments.

Reset
REQ-031 rst=1 SHALL, with no clock edge required, force:
- state IDLE and counters 0;
- pix_d=0, pix_hs=0, pix_vs=0, frame_done=0, busy=0, frame_cnt=0;
- latched configuration cleared to 0.
REQ-032 After rst falls with enable=1, pix_vs SHALL rise on the second rising clk edge.

Structure
REQ-033 The shared package raw_pattern_pkg SHALL hold:
- the state enum;
- the pattern_sel encodings;
- the Bayer phase constants;
- the 8-entry colour-bar RGB table;
- BOX_SIZE=64 and CHECK_SHIFT=5.
REQ-034 One sub-module, raw_pattern_pixel, SHALL map (x, y, latched config) to the 10-bit Bayer value; raw_pattern_tx SHALL hold the FSM, counters and output registers.

Verification
REQ-035 Timing: defaults, enable=1, sel=1 -> per frame:
- pix_hs rises FV_LV=16 cycles after pix_vs;
- 480 pix_hs pulses of exactly 640 cycles, separated by 160 low cycles;
- pix_vs low for 8000 cycles between frames;
- frame_done one cycle per frame.
REQ-036 Ramp data: sel=1 -> line 0 pix_d reads 0,1,...,639; line 479 is identical.
REQ-037 Colour bars: sel=0 ->
- (x0,y0)=0x3FF; (x1,y0)=0x3FF; (x81,y0)=0x3FF (yellow R);
- (x480,y1)=0x3FF (blue B); (x481,y1)=0;
- (x560,y1)=0 (black).
REQ-038 Green box: sel=2, box_x=100, box_y=50 ->
- (100,50)=0x3FF; (101,50)=0; (101,51)=0x3FF; (100,49)=0; (164,50)=0;
- changing box_x to 200 mid-frame leaves the current frame unchanged and moves the box in the next frame.
REQ-039 Enable drop: enable deasserted at line 100 -> 480 lines still emitted, one frame_done, frame_cnt+1, then pix_vs=0 and busy=0 after VBLANK.
REQ-040 Reset mid-line: rst asserted mid-line between clock edges -> all outputs 0 immediately and frame_cnt=0; after release, a new frame starts at (0,0).
